aes_cipher_scheduler: RTL

//  Shares one pipelined aes_cipher core among NUM_REQ requesters using round-robin arbitration.

---
 rtl/aes_cipher_scheduler_pkg.sv | 40 ++++
 rtl/aes_cipher_scheduler_rsp_fifo.sv | 60 ++++++
 rtl/aes_cipher_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/aes_cipher_scheduler_pkg.sv
// Shared definitions for the AES cipher scheduler.
//   - Sizing constants: requester count, key slots, response FIFO depth, block width.
//   - rsp_entry_t: one buffered response (ciphertext plus originating requester id).
//   - rr_pick(): round-robin choice of the first valid requester at or after a pointer.
package aes_cipher_scheduler_pkg;

  localparam int NUM_REQ    = 4;
  localparam int KEY_SLOTS  = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int DATA_WIDTH = 128;

  localparam int KEY_SEL_W = $clog2(KEY_SLOTS);
  localparam int ID_W      = $clog2(NUM_REQ);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  // One extra bit so a completely full FIFO count is representable.
  localparam int CNT_W     = PTR_W + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_W-1:0]       id;
  } rsp_entry_t;

  localparam int ENTRY_W = $bits(rsp_entry_t);

  // Walks from the farthest candidate back to ptr so that the nearest valid
  // requester (in wrap-around order starting at ptr) overwrites the others.
  // Returns ptr when nothing is valid; callers qualify with |valid.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (valid[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/aes_cipher_scheduler_rsp_fifo.sv
// Response FIFO for the AES cipher scheduler.
//   clk, rst_n   : clock, asynchronous active-low reset (pointers and count only)
//   push_i       : write push_data_i (caller guarantees not full)
//   push_data_i  : packed rsp_entry_t
//   pop_i        : drop the head entry (caller guarantees not empty)
//   head_o       : current head entry (first-word fall-through)
//   empty_o      : no entries stored
//   count_o      : number of stored entries, 0..FIFO_DEPTH
module aes_cipher_scheduler_rsp_fifo
  import aes_cipher_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] head_o,
  output logic               empty_o,
  output logic [CNT_W-1:0]   count_o
);

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  // Push and pop together leave the count unchanged, which is legal when full.
  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/aes_cipher_scheduler.sv
// Shares one pipelined aes_cipher core among NUM_REQ requesters.
//   clk, rst_n           : clock, asynchronous active-low reset (shared with the core)
//   en_i                 : 1 allows new issues; 0 drains in-flight blocks only
//   req_valid_i/ready_o  : per-requester handshake, ready is one-hot or zero
//   req_data_i           : plaintexts, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_key_sel_i        : key slots, requester i at [i*KEY_SEL_W +: KEY_SEL_W]
//   cipher_start_o       : core start, one cycle after the request handshake
//   cipher_plaintext_o   : core plaintext, valid with cipher_start_o
//   cipher_key_sel_o     : key-store select, valid in the core's capture cycle
//   cipher_cyphertext_i  : core result, valid with cipher_done_i
//   cipher_done_i        : core completion strobe
//   rsp_valid_o/ready_i  : response handshake
//   rsp_data_o, rsp_id_o : ciphertext and originating requester
//   idle_o               : nothing in flight and response FIFO empty
//   err_done_o           : sticky, core signalled done with no block in flight
module aes_cipher_scheduler
  import aes_cipher_scheduler_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ*KEY_SEL_W-1:0]   req_key_sel_i,
  output logic                           cipher_start_o,
  output logic [DATA_WIDTH-1:0]          cipher_plaintext_o,
  output logic [KEY_SEL_W-1:0]           cipher_key_sel_o,
  input  logic [DATA_WIDTH-1:0]          cipher_cyphertext_i,
  input  logic                           cipher_done_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [DATA_WIDTH-1:0]          rsp_data_o,
  output logic [ID_W-1:0]                rsp_id_o,
  output logic                           idle_o,
  output logic                           err_done_o
);

  logic                  issue;
  logic                  credit_ok;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic [ID_W-1:0]       grant_idx;
  logic [ID_W-1:0]       rr_ptr_q;
  logic [ID_W-1:0]       rr_ptr_d;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      in_flight_q;
  logic [CNT_W-1:0]      in_flight_d;
  logic [CNT_W:0]        occupancy;
  logic                  start_q;
  logic [DATA_WIDTH-1:0] pt_q;
  logic [ID_W-1:0]       id_q;
  logic [KEY_SEL_W-1:0]  key_pend_q;
  logic [KEY_SEL_W-1:0]  key_sel_q;
  logic [1:0]            tag_v_q;
  logic [ID_W-1:0]       tag_id_q [2];
  logic                  err_q;
  rsp_entry_t            push_entry;
  rsp_entry_t            head_entry;

  // Every block counted from its handshake until it lands in the FIFO, plus
  // everything buffered. Pops this cycle are deliberately not credited, so the
  // FIFO can never be pushed while full even if rsp_ready stays low forever.
  assign occupancy = {1'b0, fifo_count} + {1'b0, in_flight_q};
  assign credit_ok = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign grant_idx = rr_pick(req_valid_i, rr_ptr_q);
  assign issue     = en_i & credit_ok & (|req_valid_i);

  always_comb begin
    req_ready_o = '0;
    if (issue) req_ready_o[grant_idx] = 1'b1;
  end

  assign rr_ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
  assign push        = cipher_done_i & tag_v_q[1];
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign in_flight_d = in_flight_q + CNT_W'(issue) - CNT_W'(push);

  // Issue stage: start/plaintext one cycle after the handshake, key select one
  // cycle later still so it is stable while the core captures the plaintext.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      start_q     <= 1'b0;
      pt_q        <= '0;
      id_q        <= '0;
      key_pend_q  <= '0;
      key_sel_q   <= '0;
      in_flight_q <= '0;
      err_q       <= 1'b0;
    end else begin
      start_q     <= issue;
      in_flight_q <= in_flight_d;
      if (issue) begin
        rr_ptr_q   <= rr_ptr_d;
        pt_q       <= req_data_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        id_q       <= grant_idx;
        key_pend_q <= req_key_sel_i[grant_idx*KEY_SEL_W +: KEY_SEL_W];
      end
      if (start_q) key_sel_q <= key_pend_q;
      if (cipher_done_i && !tag_v_q[1]) err_q <= 1'b1;
    end
  end

  // Tag pipe: the id rides alongside the core so stage 1 meets cipher_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q     <= '0;
      tag_id_q[0] <= '0;
      tag_id_q[1] <= '0;
    end else begin
      tag_v_q     <= {tag_v_q[0], start_q};
      tag_id_q[0] <= id_q;
      tag_id_q[1] <= tag_id_q[0];
    end
  end

  assign push_entry.data = cipher_cyphertext_i;
  assign push_entry.id   = tag_id_q[1];

  aes_cipher_scheduler_rsp_fifo u_rsp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_entry),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign cipher_start_o     = start_q;
  assign cipher_plaintext_o = pt_q;
  assign cipher_key_sel_o   = key_sel_q;
  assign rsp_valid_o        = !fifo_empty;
  // Gate the head so stale storage never shows on the response port.
  assign rsp_data_o         = fifo_empty ? '0 : head_entry.data;
  assign rsp_id_o           = fifo_empty ? '0 : head_entry.id;
  assign idle_o             = (in_flight_q == '0) && fifo_empty;
  assign err_done_o         = err_q;

endmodule
